// File: rtl/spi_fifo_shifter_pkg.sv
// rtl/spi_fifo_shifter_pkg.sv - shared types and constants for the SPI FIFO shifter
// Purpose: FSM state encoding and bit-counter width helper.
// Ports: none (package).
package spi_fifo_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  // The bit counter must be able to hold the value D_SIZE itself (word-done test).
  function automatic int bit_cnt_width(input int d_size);
    return $clog2(d_size + 1);
  endfunction

  localparam int DEF_D_SIZE    = 16;
  localparam int DEF_BIT_CNT_W = bit_cnt_width(DEF_D_SIZE);

endpackage

// File: rtl/spi_fifo_shifter_clk_gen.sv
// rtl/spi_fifo_shifter_clk_gen.sv - SCLK half-period counter and edge strobes
// Purpose: counts 0..clk_div while running, toggles SCLK on expiry when allowed.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_run             count enable (FSM not idle); counter held at 0 otherwise
//   i_toggle_en       SCLK may toggle on expiry (SHIFT state)
//   i_clk_div         half-period = i_clk_div+1 cycles
//   o_sclk            registered SPI clock, idle low
//   o_tick            half-period expiry strobe
//   o_rise / o_fall   expiry that will drive SCLK 0->1 / 1->0 at the next edge
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_toggle_en,
  input  logic [DIV_W-1:0] i_clk_div,
  output logic             o_sclk,
  output logic             o_tick,
  output logic             o_rise,
  output logic             o_fall
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             sclk_q;

  // The divider is re-sampled only at expiry so a mid-word change never
  // lets the counter run past its terminal value.
  assign o_tick = i_run && (cnt_q == div_q);
  assign o_rise = o_tick && i_toggle_en && !sclk_q;
  assign o_fall = o_tick && i_toggle_en && sclk_q;
  assign o_sclk = sclk_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!i_run) begin
      cnt_q  <= '0;
      div_q  <= i_clk_div;
      sclk_q <= 1'b0;
    end else begin
      if (o_tick) begin
        cnt_q <= '0;
        div_q <= i_clk_div;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (o_rise || o_fall) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/spi_fifo_shifter.sv
// rtl/spi_fifo_shifter.sv - SPI mode-0 master fed from a show-ahead FIFO
// Purpose: pops words from the FIFO, shifts them out MSB-first, captures MISO.
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_enable                        permits starting/continuing transfers
//   i_clk_div                       SCLK half-period = i_clk_div+1 cycles
//   i_fifo_data, i_fifo_empty       FIFO show-ahead read port
//   o_fifo_rd_inc                   one-cycle pop strobe
//   o_sclk, o_mosi, i_miso, o_cs_n  SPI bus
//   o_rx_data, o_rx_valid           received word and its update pulse
//   o_busy                          FSM not idle
module spi_fifo_shifter
  import spi_fifo_shifter_pkg::*;
#(
  parameter int D_SIZE = 16,
  parameter int DIV_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic [D_SIZE-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_inc,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n,
  output logic [D_SIZE-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
);

  localparam int              BIT_W    = bit_cnt_width(D_SIZE);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(D_SIZE);

  state_e            state_q;
  logic [D_SIZE-1:0] tx_q;
  logic [D_SIZE-1:0] rx_q;
  logic [D_SIZE-1:0] rx_data_q;
  logic [BIT_W-1:0]  bit_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              rx_valid_q;

  logic tick;
  logic rise;
  logic fall;
  logic can_load;
  logic word_done;
  logic load;

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (state_q != ST_IDLE),
    .i_toggle_en(state_q == ST_SHIFT),
    .i_clk_div  (i_clk_div),
    .o_sclk     (o_sclk),
    .o_tick     (tick),
    .o_rise     (rise),
    .o_fall     (fall)
  );

  // The pop strobe is combinational because the show-ahead data is taken in
  // the same cycle; gating with i_rst keeps it low while reset is held.
  assign can_load      = i_enable && !i_fifo_empty && !i_rst;
  assign word_done     = (state_q == ST_SHIFT) && fall && (bit_q == BIT_LAST);
  assign load          = can_load && ((state_q == ST_IDLE) || word_done);
  assign o_fifo_rd_inc = load;

  assign o_mosi     = mosi_q;
  assign o_cs_n     = cs_n_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = (state_q != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      bit_q      <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            tx_q    <= i_fifo_data;
            mosi_q  <= i_fifo_data[D_SIZE-1];
            cs_n_q  <= 1'b0;
            bit_q   <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise) begin
            rx_q  <= {rx_q[D_SIZE-2:0], i_miso};
            bit_q <= bit_q + 1'b1;
          end else if (fall) begin
            if (bit_q != BIT_LAST) begin
              mosi_q <= tx_q[D_SIZE-2];
              tx_q   <= {tx_q[D_SIZE-2:0], 1'b0};
            end else begin
              rx_data_q  <= rx_q;
              rx_valid_q <= 1'b1;
              if (load) begin
                // Back-to-back word: CS stays low, SCLK keeps its cadence.
                tx_q   <= i_fifo_data;
                mosi_q <= i_fifo_data[D_SIZE-1];
                bit_q  <= '0;
              end else begin
                state_q <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_fifo_shifter.md
Name: spi_fifo_shifter

Overview:
- Read-side consumer of the SPI controller's clock-domain-crossing FIFO, in the SPI clock domain.
- Pops words from the FIFO's show-ahead read port and shifts each word out MSB-first on MOSI (SPI mode 0), with a programmable SCLK divider.
- Captures MISO into a receive word for every transmitted word.
- Keeps CS asserted across back-to-back words while the FIFO has data.

Parameters:
D_SIZE, 16, word width in bits; must match the FIFO data width
DIV_W, 8, width of the SCLK divider input

Ports:
i_clk  input  1  SPI-domain operating clock
i_rst  input  1  asynchronous, active-high reset
i_enable  input  1  level; permits starting or continuing transfers
i_clk_div  input  DIV_W  SCLK half-period = i_clk_div+1 i_clk cycles
i_fifo_data  input  D_SIZE  FIFO read data; valid whenever i_fifo_empty=0
i_fifo_empty  input  1  FIFO empty flag
o_fifo_rd_inc  output  1  one-cycle pop strobe to FIFO read side
o_sclk  output  1  SPI clock, idle low
o_mosi  output  1  serial data out
i_miso  input  1  serial data in, already synchronised to i_clk
o_cs_n  output  1  chip select, active low
o_rx_data  output  D_SIZE  last received word
o_rx_valid  output  1  one-cycle pulse when o_rx_data updates
o_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-word): state=IDLE, o_sclk=0, o_cs_n=1, o_mosi=0, o_fifo_rd_inc=0, o_rx_data=0, o_rx_valid=0, o_busy=0. All counters and shift registers cleared.
- Half-period counter: counts 0..i_clk_div. Expiry = count==i_clk_div. Sampled each cycle; a change mid-word applies from the next expiry.
- Bit counter: width clog2(D_SIZE+1). Counts SCLK rising edges in the current word.
- IDLE:
  - On i_enable=1 and i_fifo_empty=0: latch i_fifo_data into tx shift register, assert o_fifo_rd_inc for exactly this cycle, drive o_cs_n=0, set o_mosi=data[D_SIZE-1], go SETUP.
- SETUP:
  - Wait one half-period (CS-to-SCLK setup), then go SHIFT with o_sclk=0.
- SHIFT, at each half-period expiry, toggle o_sclk:
  - Rising edge (0->1): shift i_miso into rx shift register LSB; bit counter +1.
  - Falling edge (1->0), bit counter < D_SIZE: drive next tx bit on o_mosi.
  - Falling edge, bit counter == D_SIZE: word done.
    - o_rx_data <= rx shift register; o_rx_valid pulses for 1 cycle.
    - If i_enable=1 and i_fifo_empty=0: load the next word with a pop in the same cycle, drive its MSB on o_mosi, clear bit counter, stay in SHIFT. CS stays low with no gap.
    - Otherwise go HOLD.
- HOLD:
  - Wait one half-period with o_sclk=0, then o_cs_n=1, go IDLE.
  - IDLE cannot re-start in the same cycle it is entered.
- Pop rules:
  - o_fifo_rd_inc is never asserted while i_fifo_empty=1.
  - At most one pop per word. Pops are at least 2*D_SIZE cycles apart, which tolerates the FIFO's one-cycle registered empty update.
- i_enable deasserted mid-word: the current word completes, including o_rx_valid, then HOLD -> IDLE. No word is ever truncated except by reset.
- Receive word: bit 0 is the last MISO bit sampled, bit D_SIZE-1 the first.
- Exactly D_SIZE SCLK rising edges per word. SCLK period = 2*(i_clk_div+1) i_clk cycles.

Decomposition:
- Shared package: state encoding (IDLE, SETUP, SHIFT, HOLD) as a typedef, and a clog2-based bit-counter width constant.
- One natural sub-module: spi_clk_gen. It holds the half-period counter and SCLK toggle, and outputs rise/fall strobes to the main FSM.
- Shift registers and FSM stay in the top.

Test Plan:
- D_SIZE=8, i_clk_div=1, FIFO holds 0xA5, MISO driven 0x3C MSB-first -> o_mosi 1,0,1,0,0,1,0,1 on rising edges; 8 SCLK pulses of period 4 cycles; one o_fifo_rd_inc; o_rx_data=0x3C with one o_rx_valid; o_cs_n back to 1.
- FIFO holds 0x01,0x80,0xFF, i_enable=1 -> o_cs_n low continuously; 3 pops; 24 rising edges; 3 o_rx_valid pulses; words transmitted in order.
- FIFO empty, i_enable=1 for 100 cycles -> o_cs_n=1, o_sclk=0, no pop, o_busy=0.
- i_clk_div=0 with one word -> SCLK period 2 cycles; 8 edges; correct data.
- i_enable dropped after bit 3 of word 1 of a 2-word burst -> word 1 completes with o_rx_valid; word 2 not popped; CS released after HOLD.
- i_rst pulsed at bit 5 -> outputs go to reset values in that cycle without a clock edge; after release, the next non-empty FIFO word starts a fresh transfer.
